// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, instruction width, the FIFO
// entry layout and the branch target formula used by fetch and execute.
package cpu_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Target = branch PC + 8 + signed word offset, wrapping mod 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] br_pc,
                                                 input logic [23:0] br_offset);
      return br_pc + 32'd8 + {{6{br_offset[23]}}, br_offset, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} FIFO with flush. The head entry drives the outputs
// straight from registered storage.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [31:0]            push_pc_i,
   input  logic [INSTR_W-1:0]     push_instr_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [31:0]            head_pc_o,
   output logic [INSTR_W-1:0]     head_instr_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o       = (count_q == CW'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign count_o      = count_q;
   assign head_pc_o    = mem_q[rd_ptr_q].pc;
   assign head_instr_o = mem_q[rd_ptr_q].instr;

   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Storage, pointers and occupancy; flush empties the FIFO and voids any pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is reset as well so the head outputs read zero out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (do_push) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc_i, instr: push_instr_i};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues one outstanding fetch at a
// time to variable-latency memory, buffers returned words and handles redirects.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               br_valid,
   input  logic [31:0]        br_pc,
   input  logic [23:0]        br_offset,
   output logic [INSTR_W-1:0] instruction,
   output logic [31:0]        instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   pc_next;
   logic [31:0]   br_target;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic          room_after;

   assign br_target   = branch_target(br_pc, br_offset);
   assign pc_next     = pc_q + 32'd4;
   assign instr_valid = !fifo_empty;
   // The FIFO gives flush priority, so a pop during a branch is void.
   assign fifo_pop    = instr_valid && instr_ready;
   // Space left once this response is pushed: count + 1 - pop < DEPTH.
   // A response only arrives while count < DEPTH, so a pop always leaves room.
   assign room_after  = (fifo_count < CW'(DEPTH - 1)) || fifo_pop;

   // State and PC registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state and next PC; a redirect overrides everything else.
   always_comb begin
      // NOTE: defaults first so no path through the process leaves a latch.
      state_d = state_q;
      pc_d    = pc_q;
      if (br_valid) begin
         pc_d = br_target;
         // An outstanding response still has to be swallowed unless it is arriving now.
         if (state_q != FETCH) begin
            state_d = imem_rvalid ? FETCH : DROP;
         end
      end else begin
         unique case (state_q)
            FETCH: if (!fifo_full) state_d = WAIT;
            WAIT: begin
               if (imem_rvalid) begin
                  pc_d = pc_next;
                  if (!room_after) state_d = FETCH;
               end
            end
            DROP:    if (imem_rvalid) state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end
   end

   // Memory request and FIFO push; nothing is issued during reset or a redirect.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = '0;
      fifo_push = 1'b0;
      if (reset && !br_valid) begin
         unique case (state_q)
            FETCH: begin
               if (!fifo_full) begin
                  imem_req  = 1'b1;
                  imem_addr = pc_q;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  fifo_push = 1'b1;
                  if (room_after) begin
                     imem_req  = 1'b1;
                     imem_addr = pc_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (reset),
      .push_i      (fifo_push),
      .push_pc_i   (pc_q),
      .push_instr_i(imem_rdata),
      .pop_i       (fifo_pop),
      .flush_i     (br_valid),
      .head_pc_o   (instr_pc),
      .head_instr_o(instruction),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder. Keeps the PC and issues word fetches to instruction memory, which has variable latency. Buffers returned words in a small FIFO and presents them with their PC to the decoder under a valid/ready handshake. Accepts branch redirects whose 24-bit word offset comes from the decoder's immediate field.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, instruction FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  out  1  single-cycle fetch request pulse
imem_addr  out  32  word-aligned fetch address, valid with imem_req
imem_rvalid  in  1  read data valid, at least 1 cycle after imem_req
imem_rdata  in  32  fetched instruction word
br_valid  in  1  branch redirect, single-cycle pulse
br_pc  in  32  PC of the branch instruction
br_offset  in  24  signed word offset (decoder inm)
instruction  out  32  instruction word to decoder (head of FIFO)
instr_pc  out  32  PC of instruction
instr_valid  out  1  FIFO not empty
instr_ready  in  1  decoder accepts; pop when valid&&ready

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, FIFO empty, state=FETCH. imem_req=0, imem_addr=0, instruction=0, instr_pc=0, instr_valid=0.
- At most one memory request is outstanding. imem_rvalid is ignored outside WAIT/DROP.
- States:
  - FETCH: if count<DEPTH and !br_valid, pulse imem_req with imem_addr=pc, then go to WAIT.
  - WAIT: on imem_rvalid with no branch, push {pc, rdata} and set pc=pc+4. If (count + 1 - pop) < DEPTH, issue the next request at pc+4 in the same cycle and stay in WAIT. Otherwise go to FETCH.
  - DROP: discard the next imem_rvalid, then go to FETCH.
- Branch target = br_pc + 8 + (sign_extend(br_offset) << 2), computed mod 2^32.
- Branch in any state:
  - FIFO is flushed the same cycle; any pop that cycle is void.
  - pc is set to the target.
  - No imem_req is issued that cycle.
- Branch while in WAIT without rvalid: go to DROP. Branch in the same cycle as imem_rvalid: the response is dropped and the state goes to FETCH. Branch in DROP: stay in DROP with the new target.
- Throughput: with 1-cycle memory latency and instr_ready held at 1, one instruction per cycle after the first fetch. First instr_valid appears 2 cycles after reset release (req cycle 0, rvalid cycle 1, valid cycle 2).
- FIFO:
  - Push and pop in the same cycle are both allowed when the FIFO is full.
  - Pointers wrap modulo DEPTH.
  - instruction and instr_pc come straight from the head entry (registered storage), with no combinational path from imem_rdata.
- pc wraps from 0xFFFF_FFFC to 0.
- Reset during WAIT: state returns to FETCH. A late imem_rvalid that arrives afterwards is ignored.

Decomposition:
- Shared package (cpu_pkg): the fetch state enum (FETCH, WAIT, DROP), the INSTR_W=32 constant, and a branch_target function, so execute/branch logic uses the same formula.
- Sub-module fetch_fifo: a DEPTH-entry {pc, instr} FIFO with push, pop, flush, count, full and empty. It uses the same asynchronous active-low reset.

Test Plan:
- Release reset with 1-cycle memory and instr_ready=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_pc 0x0, 0x4, 0x8 follow 2 cycles later with no bubbles.
- Hold instr_ready=0 -> exactly DEPTH=2 words buffered, imem_req stays 0. Raise ready -> words drain in order and fetch resumes at 0x8.
- br_valid with br_pc=0x10, br_offset=24'hFFFFFE -> next imem_addr=0x10. With br_offset=24'h000001 -> next imem_addr=0x1C. The FIFO is empty in the cycle after the branch.
- 3-cycle memory latency, branch to 0x40 one cycle after the request -> the stale rdata is never presented; the next imem_addr is 0x40; the first valid instr_pc is 0x40.
- Branch in the same cycle as imem_rvalid -> the word is dropped, instr_valid=0 next cycle, and imem_req to the target the following cycle.
- Reset asserted mid-WAIT, rvalid pulsed during reset and once after release -> no word enters the FIFO; the first request after release is at RESET_PC.
